// File: rtl/decode_queue.sv
// decode_queue: MIPS-I decode-and-buffer stage between fetch and issue.
// Each accepted instruction is decoded into a compact control bundle and kept
// with its raw word and PC in a DEPTH-entry circular FIFO. An exception-raising
// instruction or eret stops further input until the next flush.
// Optional feature: define DECODE_BYPASS_EN for a same-cycle path from an
// empty queue straight to the outputs.
module decode_queue #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [31:0]      out_pc,
  output logic [2:0]       out_class,
  output logic             out_rs_read,
  output logic             out_rt_read,
  output logic [4:0]       out_wdst,
  output logic [2:0]       out_exc,
  output logic [PTR_W:0]   count
);

  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [2:0] CLS_ALU   = 3'd0;
  localparam logic [2:0] CLS_LOAD  = 3'd1;
  localparam logic [2:0] CLS_STORE = 3'd2;
  localparam logic [2:0] CLS_BR    = 3'd3;
  localparam logic [2:0] CLS_JMP   = 3'd4;
  localparam logic [2:0] CLS_MDU   = 3'd5;
  localparam logic [2:0] CLS_CP0   = 3'd6;
  localparam logic [2:0] CLS_INV   = 3'd7;

  localparam logic [2:0] EXC_BP  = 3'b100;
  localparam logic [2:0] EXC_SYS = 3'b010;
  localparam logic [2:0] EXC_RI  = 3'b001;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [2:0]  cls;
    logic        rs_read;
    logic        rt_read;
    logic [4:0]  wdst;
    logic [2:0]  exc;
  } entry_t;

  typedef enum logic {ST_RUN, ST_HOLD} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;

  logic [5:0]         w_op;
  logic [5:0]         w_funct;
  logic [4:0]         w_rs;
  logic [4:0]         w_rt;
  logic [4:0]         w_rd;
  entry_t             w_dec;
  entry_t             w_out;
  logic               w_known;
  logic               w_eret;
  logic               w_push;
  logic               w_pop;
  logic               w_write;
  logic               w_bypass;

  assign w_op    = in_inst[31:26];
  assign w_rs    = in_inst[25:21];
  assign w_rt    = in_inst[20:16];
  assign w_rd    = in_inst[15:11];
  assign w_funct = in_inst[5:0];

  // Decode the incoming instruction into the control bundle
  always_comb begin
    w_dec         = '0;
    w_dec.inst    = in_inst;
    w_dec.pc      = in_pc;
    w_dec.rs_read = 1'b1;
    w_known       = 1'b1;
    w_eret        = 1'b0;
    case (w_op)
      6'h00: begin
        case (w_funct)
          6'h00, 6'h02, 6'h03: begin
            w_dec.cls = CLS_ALU; w_dec.rs_read = 1'b0; w_dec.rt_read = 1'b1; w_dec.wdst = w_rd;
          end
          6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23,
          6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin
            w_dec.cls = CLS_ALU; w_dec.rt_read = 1'b1; w_dec.wdst = w_rd;
          end
          6'h08: w_dec.cls = CLS_JMP;
          6'h09: begin
            w_dec.cls = CLS_JMP; w_dec.wdst = w_rd;
          end
          6'h0C: begin
            w_dec.cls = CLS_CP0; w_dec.rs_read = 1'b0; w_dec.exc = EXC_SYS;
          end
          6'h0D: begin
            w_dec.cls = CLS_CP0; w_dec.rs_read = 1'b0; w_dec.exc = EXC_BP;
          end
          6'h10, 6'h12: begin
            w_dec.cls = CLS_MDU; w_dec.rs_read = 1'b0; w_dec.wdst = w_rd;
          end
          6'h11, 6'h13: w_dec.cls = CLS_MDU;
          6'h18, 6'h19, 6'h1A, 6'h1B: begin
            w_dec.cls = CLS_MDU; w_dec.rt_read = 1'b1;
          end
          default: w_known = 1'b0;
        endcase
      end
      6'h01: begin
        case (w_rt)
          5'h00, 5'h01: w_dec.cls = CLS_BR;
          5'h10, 5'h11: begin
            w_dec.cls = CLS_BR; w_dec.wdst = 5'd31;
          end
          default: w_known = 1'b0;
        endcase
      end
      6'h02: begin
        w_dec.cls = CLS_JMP; w_dec.rs_read = 1'b0;
      end
      6'h03: begin
        w_dec.cls = CLS_JMP; w_dec.rs_read = 1'b0; w_dec.wdst = 5'd31;
      end
      6'h04, 6'h05: begin
        w_dec.cls = CLS_BR; w_dec.rt_read = 1'b1;
      end
      6'h06, 6'h07: w_dec.cls = CLS_BR;
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        w_dec.cls = CLS_ALU; w_dec.wdst = w_rt;
      end
      6'h10: begin
        w_dec.cls     = CLS_CP0;
        w_dec.rs_read = 1'b0;
        if (w_rs == 5'h00) begin
          w_dec.wdst = w_rt;
        end else if (w_rs == 5'h04) begin
          w_dec.rt_read = 1'b1;
        end else if (w_rs == 5'h10 && w_funct == 6'h18) begin
          w_eret = 1'b1;
        end else begin
          w_known = 1'b0;
        end
      end
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: begin
        w_dec.cls = CLS_LOAD; w_dec.wdst = w_rt;
      end
      6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E: begin
        w_dec.cls = CLS_STORE; w_dec.rt_read = 1'b1;
      end
      default: w_known = 1'b0;
    endcase
    // Anything unrecognised becomes a reserved-instruction bundle
    if (!w_known) begin
      w_dec.cls     = CLS_INV;
      w_dec.rs_read = 1'b1;
      w_dec.rt_read = 1'b0;
      w_dec.wdst    = 5'd0;
      w_dec.exc     = EXC_RI;
      w_eret        = 1'b0;
    end
  end

  assign in_ready = (r_state == ST_RUN) & (r_count < CNT_W'(DEPTH)) & ~flush & ~rst;
  assign w_push   = in_valid & in_ready;
  assign w_pop    = (r_count != '0) & out_ready;

`ifdef DECODE_BYPASS_EN
  assign w_bypass = w_push & (r_count == '0);
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed instruction consumed in the same cycle never occupies an entry
  assign w_write   = w_push & ~(w_bypass & out_ready);
  assign out_valid = (r_count != '0) | w_bypass;
  assign w_out     = w_bypass ? w_dec : r_mem[r_head];

  assign out_inst    = w_out.inst;
  assign out_pc      = w_out.pc;
  assign out_class   = w_out.cls;
  assign out_rs_read = w_out.rs_read;
  assign out_rt_read = w_out.rt_read;
  assign out_wdst    = w_out.wdst;
  assign out_exc     = w_out.exc;
  assign count       = r_count;

  // Accept/hold state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  // Enter HOLD after an excepting instruction or eret; flush reopens input
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_RUN;
    end else if (r_state == ST_RUN && w_push && (w_dec.exc != 3'b000 || w_eret)) begin
      w_state_nxt = ST_HOLD;
    end
  end

  // FIFO storage, pointers and occupancy; flush overrides push and pop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_write) begin
        r_mem[r_tail] <= w_dec;
        r_tail        <= r_tail + PTR_W'(1);
      end
      if (w_pop) r_head <= r_head + PTR_W'(1);
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: stimulus pushes expected bundles, a
// monitor pops and compares whenever the DUT hands an entry to issue.
module tb_decode_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [2:0]  cls;
    logic        rs_read;
    logic        rt_read;
    logic [4:0]  wdst;
    logic [2:0]  exc;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [31:0]      in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_inst;
  logic [31:0]      out_pc;
  logic [2:0]       out_class;
  logic             out_rs_read;
  logic             out_rt_read;
  logic [4:0]       out_wdst;
  logic [2:0]       out_exc;
  logic [PTR_W:0]   count;

  exp_t exp_q[$];
  exp_t vecs[$];
  exp_t mon_got;
  exp_t mon_exp;
  int   errors = 0;
  int   checks = 0;
  int   stalls = 0;

  decode_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_class(out_class), .out_rs_read(out_rs_read), .out_rt_read(out_rt_read),
    .out_wdst(out_wdst), .out_exc(out_exc), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] inst, input logic [31:0] pc,
                              input logic [2:0] cls, input logic rs, input logic rt,
                              input logic [4:0] wd, input logic [2:0] exc);
    exp_t e;
    e.inst = inst; e.pc = pc; e.cls = cls; e.rs_read = rs; e.rt_read = rt;
    e.wdst = wd; e.exc = exc;
    return e;
  endfunction

  // Offer one instruction until accepted; record its expected bundle
  task automatic push(input exp_t e);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_inst  = e.inst;
    in_pc    = e.pc;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        done = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: inst %0h never accepted", e.inst);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Let issue consume everything outstanding, bounded
  task automatic drain();
    bit empty;
    empty = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 40 && !empty; n++) begin
      @(negedge clk);
      #3;
      if (count == '0 && exp_q.size() == 0) empty = 1'b1;
    end
    @(posedge clk); #1;
    check("drain", 80'(empty), 80'(1));
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
  endtask

  // Monitor: every issued head entry must match the oldest expected bundle
  always begin
    @(negedge clk);
    #2;
    if (!rst && out_valid && out_ready) begin
      mon_got = {out_inst, out_pc, out_class, out_rs_read, out_rt_read, out_wdst, out_exc};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %0h with empty scoreboard", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        check("issue", 80'(mon_got), 80'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;

    // reset
    @(negedge clk);
    check("rst_in_ready", 80'(in_ready), 80'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_count", 80'(count), 80'(0));
    check("rst_out_valid", 80'(out_valid), 80'(0));
    check("rst_out_data", 80'({out_inst, out_pc, out_class, out_rs_read, out_rt_read, out_wdst, out_exc}), 80'(0));
    check("rst_in_ready_after", 80'(in_ready), 80'(1));
    @(posedge clk); #1;

    // addu: latency and decode
    out_ready = 1'b1;
    e = mk(32'h00221821, 32'hBFC00000, 3'd0, 1'b1, 1'b1, 5'd3, 3'b000);
    in_valid = 1'b1; in_inst = e.inst; in_pc = e.pc;
    @(negedge clk);
    check("addu_in_ready", 80'(in_ready), 80'(1));
`ifdef DECODE_BYPASS_EN
    check("bypass_same_cycle_valid", 80'(out_valid), 80'(1));
    check("bypass_count_zero", 80'(count), 80'(0));
`else
    check("no_same_cycle_valid", 80'(out_valid), 80'(0));
`endif
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
`ifdef DECODE_BYPASS_EN
    check("bypass_count_stays", 80'(count), 80'(0));
`else
    check("latency_one_valid", 80'(out_valid), 80'(1));
    check("latency_one_count", 80'(count), 80'(1));
`endif
    @(posedge clk); #1;
    drain();

    // decode table, back to back with issue always ready
    vecs.push_back(mk(32'h0C000010, 32'hBFC00004, 3'd4, 1'b0, 1'b0, 5'd31, 3'b000)); // jal
    vecs.push_back(mk(32'h8C450004, 32'hBFC00008, 3'd1, 1'b1, 1'b0, 5'd5,  3'b000)); // lw
    vecs.push_back(mk(32'hAC450008, 32'hBFC0000C, 3'd2, 1'b1, 1'b1, 5'd0,  3'b000)); // sw
    vecs.push_back(mk(32'h10220003, 32'hBFC00010, 3'd3, 1'b1, 1'b1, 5'd0,  3'b000)); // beq
    vecs.push_back(mk(32'h00021080, 32'hBFC00014, 3'd0, 1'b0, 1'b1, 5'd2,  3'b000)); // sll
    vecs.push_back(mk(32'h00220018, 32'hBFC00018, 3'd5, 1'b1, 1'b1, 5'd0,  3'b000)); // mult
    vecs.push_back(mk(32'h00002010, 32'hBFC0001C, 3'd5, 1'b0, 1'b0, 5'd4,  3'b000)); // mfhi
    vecs.push_back(mk(32'h04310004, 32'hBFC00020, 3'd3, 1'b1, 1'b0, 5'd31, 3'b000)); // bgezal
    vecs.push_back(mk(32'h24070005, 32'hBFC00024, 3'd0, 1'b1, 1'b0, 5'd7,  3'b000)); // addiu
    vecs.push_back(mk(32'h03E00008, 32'hBFC00028, 3'd4, 1'b1, 1'b0, 5'd0,  3'b000)); // jr
    vecs.push_back(mk(32'h40086000, 32'hBFC0002C, 3'd6, 1'b0, 1'b0, 5'd8,  3'b000)); // mfc0
    vecs.push_back(mk(32'h40896000, 32'hBFC00030, 3'd6, 1'b0, 1'b1, 5'd0,  3'b000)); // mtc0
    vecs.push_back(mk(32'h00220021, 32'hBFC00034, 3'd0, 1'b1, 1'b1, 5'd0,  3'b000)); // addu rd=0
    vecs.push_back(mk(32'h3C011234, 32'hBFC00038, 3'd0, 1'b1, 1'b0, 5'd1,  3'b000)); // lui
    vecs.push_back(mk(32'hA8450000, 32'hBFC0003C, 3'd2, 1'b1, 1'b1, 5'd0,  3'b000)); // swl
    vecs.push_back(mk(32'h98450000, 32'hBFC00040, 3'd1, 1'b1, 1'b0, 5'd5,  3'b000)); // lwr
    vecs.push_back(mk(32'h0040F809, 32'hBFC00044, 3'd4, 1'b1, 1'b0, 5'd31, 3'b000)); // jalr
    vecs.push_back(mk(32'h00600011, 32'hBFC00048, 3'd5, 1'b1, 1'b0, 5'd0,  3'b000)); // mthi
    vecs.push_back(mk(32'h18200002, 32'hBFC0004C, 3'd3, 1'b1, 1'b0, 5'd0,  3'b000)); // blez
    stalls = 0;
    foreach (vecs[i]) push(vecs[i]);
    check("full_throughput_stalls", 80'(stalls), 80'(0));
    drain();

    // fill to DEPTH, hold, partial pop, wrap
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push(mk(32'h24000000 | 32'(i + 1), 32'h00001000 + 32'(4 * i), 3'd0, 1'b1, 1'b0, 5'd0, 3'b000));
    @(negedge clk);
    check("full_count", 80'(count), 80'(4));
    check("full_in_ready", 80'(in_ready), 80'(0));
    check("full_out_valid", 80'(out_valid), 80'(1));
    @(posedge clk); #1;
    @(negedge clk);
    check("stall_hold_inst", 80'(out_inst), 80'(32'h24000001));
    check("stall_hold_pc", 80'(out_pc), 80'(32'h00001000));
    @(posedge clk); #1;
    out_ready = 1'b1;
    step(2);
    out_ready = 1'b0;
    @(negedge clk);
    check("after_pop2_count", 80'(count), 80'(2));
    @(posedge clk); #1;
    push(mk(32'h8C430010, 32'h00001010, 3'd1, 1'b1, 1'b0, 5'd3, 3'b000));
    push(mk(32'hAC430014, 32'h00001014, 3'd2, 1'b1, 1'b1, 5'd0, 3'b000));
    @(negedge clk);
    check("wrap_count", 80'(count), 80'(4));
    check("wrap_in_ready", 80'(in_ready), 80'(0));
    @(posedge clk); #1;
    drain();

    // syscall: HOLD while draining, flush reopens
    out_ready = 1'b0;
    push(mk(32'h00221821, 32'h00002000, 3'd0, 1'b1, 1'b1, 5'd3, 3'b000));
    push(mk(32'h0000000C, 32'h00002004, 3'd6, 1'b0, 1'b0, 5'd0, 3'b010));
    @(negedge clk);
    check("sys_hold_in_ready", 80'(in_ready), 80'(0));
    check("sys_count", 80'(count), 80'(2));
    @(posedge clk); #1;
    out_ready = 1'b1;
    step(3);
    @(negedge clk);
    check("sys_drained_count", 80'(count), 80'(0));
    check("sys_drained_in_ready", 80'(in_ready), 80'(0));
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_blocks_ready", 80'(in_ready), 80'(0));
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("sys_flush_count", 80'(count), 80'(0));
    check("sys_flush_in_ready", 80'(in_ready), 80'(1));
    @(posedge clk); #1;

    // reserved opcode; flush with a simultaneous push
    out_ready = 1'b0;
    push(mk(32'hFC000000, 32'h00003000, 3'd7, 1'b1, 1'b0, 5'd0, 3'b001));
    @(negedge clk);
    check("ri_class_exc", 80'({out_class, out_exc}), 80'({3'd7, 3'b001}));
    check("ri_hold_in_ready", 80'(in_ready), 80'(0));
    @(posedge clk); #1;
    in_valid = 1'b1; in_inst = 32'h00221821; in_pc = 32'h00003004;
    do_flush();
    in_valid = 1'b0;
    @(negedge clk);
    check("ri_flush_count", 80'(count), 80'(0));
    check("ri_flush_out_valid", 80'(out_valid), 80'(0));
    @(posedge clk); #1;

    // flush in RUN with entries queued and a push offered
    push(mk(32'h00221821, 32'h00004000, 3'd0, 1'b1, 1'b1, 5'd3, 3'b000));
    push(mk(32'h8C450004, 32'h00004004, 3'd1, 1'b1, 1'b0, 5'd5, 3'b000));
    in_valid = 1'b1; in_inst = 32'h24070005; in_pc = 32'h00004008;
    do_flush();
    in_valid = 1'b0;
    step(1);
    @(negedge clk);
    check("run_flush_drops_push", 80'(count), 80'(0));
    check("run_flush_in_ready", 80'(in_ready), 80'(1));
    @(posedge clk); #1;

    // break and eret both close the input until flush
    out_ready = 1'b1;
    push(mk(32'h0000000D, 32'h00005000, 3'd6, 1'b0, 1'b0, 5'd0, 3'b100));
    @(negedge clk);
    check("break_hold", 80'(in_ready), 80'(0));
    @(posedge clk); #1;
    drain();
    do_flush();
    push(mk(32'h42000018, 32'h00005004, 3'd6, 1'b0, 1'b0, 5'd0, 3'b000));
    @(negedge clk);
    check("eret_hold", 80'(in_ready), 80'(0));
    @(posedge clk); #1;
    drain();
    do_flush();
    @(negedge clk);
    check("final_in_ready", 80'(in_ready), 80'(1));
    check("scoreboard_empty", 80'(exp_q.size()), 80'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
